aes_inv_key_scheduler: RTL and testbench

- Iterative AES-128 inverse key schedule for the decryption datapath.
- Takes the round-10 key and steps the schedule backwards, one round per accepted transfer.
- Streams round keys 10, 9, …, 0 over a valid/ready interface, so the inverse cipher consumes them in the order it needs them.
- Replaces eleven parallel round-key buses with one 128-bit register and a single g-function: 4 S-box lookups plus Rcon.

---
 rtl/aes_inv_key_scheduler.sv | 174 +++++++++++++++++
 tb/tb_aes_inv_key_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_key_scheduler.sv
// Iterative AES-128 inverse key schedule: streams round keys 10..0 from the round-10 key.
// Optional macro AES_INV_KEY_EQINV_EN: emit InvMixColumns(key) for rounds 9..1 (equivalent inverse cipher).
module aes_inv_key_scheduler #(
    parameter int EMIT_ROUND0 = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         start_ready,
    input  logic [127:0] last_key,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_round,
    output logic         done
);
    typedef enum logic {IDLE, EMIT} state_t;

    localparam logic [3:0] FINAL_RND = (EMIT_ROUND0 != 0) ? 4'd0 : 4'd1;

    state_t       r_state;
    logic [127:0] r_key;
    logic [3:0]   r_round;
    logic         r_valid;
    logic         r_start_ready;
    logic         r_done;

    function automatic logic [7:0] f_sbox(input logic [7:0] a);
        f_sbox = 8'h00;
        case (a)
            8'h00: f_sbox = 8'h63; 8'h01: f_sbox = 8'h7c; 8'h02: f_sbox = 8'h77; 8'h03: f_sbox = 8'h7b; 8'h04: f_sbox = 8'hf2; 8'h05: f_sbox = 8'h6b; 8'h06: f_sbox = 8'h6f; 8'h07: f_sbox = 8'hc5;
            8'h08: f_sbox = 8'h30; 8'h09: f_sbox = 8'h01; 8'h0a: f_sbox = 8'h67; 8'h0b: f_sbox = 8'h2b; 8'h0c: f_sbox = 8'hfe; 8'h0d: f_sbox = 8'hd7; 8'h0e: f_sbox = 8'hab; 8'h0f: f_sbox = 8'h76;
            8'h10: f_sbox = 8'hca; 8'h11: f_sbox = 8'h82; 8'h12: f_sbox = 8'hc9; 8'h13: f_sbox = 8'h7d; 8'h14: f_sbox = 8'hfa; 8'h15: f_sbox = 8'h59; 8'h16: f_sbox = 8'h47; 8'h17: f_sbox = 8'hf0;
            8'h18: f_sbox = 8'had; 8'h19: f_sbox = 8'hd4; 8'h1a: f_sbox = 8'ha2; 8'h1b: f_sbox = 8'haf; 8'h1c: f_sbox = 8'h9c; 8'h1d: f_sbox = 8'ha4; 8'h1e: f_sbox = 8'h72; 8'h1f: f_sbox = 8'hc0;
            8'h20: f_sbox = 8'hb7; 8'h21: f_sbox = 8'hfd; 8'h22: f_sbox = 8'h93; 8'h23: f_sbox = 8'h26; 8'h24: f_sbox = 8'h36; 8'h25: f_sbox = 8'h3f; 8'h26: f_sbox = 8'hf7; 8'h27: f_sbox = 8'hcc;
            8'h28: f_sbox = 8'h34; 8'h29: f_sbox = 8'ha5; 8'h2a: f_sbox = 8'he5; 8'h2b: f_sbox = 8'hf1; 8'h2c: f_sbox = 8'h71; 8'h2d: f_sbox = 8'hd8; 8'h2e: f_sbox = 8'h31; 8'h2f: f_sbox = 8'h15;
            8'h30: f_sbox = 8'h04; 8'h31: f_sbox = 8'hc7; 8'h32: f_sbox = 8'h23; 8'h33: f_sbox = 8'hc3; 8'h34: f_sbox = 8'h18; 8'h35: f_sbox = 8'h96; 8'h36: f_sbox = 8'h05; 8'h37: f_sbox = 8'h9a;
            8'h38: f_sbox = 8'h07; 8'h39: f_sbox = 8'h12; 8'h3a: f_sbox = 8'h80; 8'h3b: f_sbox = 8'he2; 8'h3c: f_sbox = 8'heb; 8'h3d: f_sbox = 8'h27; 8'h3e: f_sbox = 8'hb2; 8'h3f: f_sbox = 8'h75;
            8'h40: f_sbox = 8'h09; 8'h41: f_sbox = 8'h83; 8'h42: f_sbox = 8'h2c; 8'h43: f_sbox = 8'h1a; 8'h44: f_sbox = 8'h1b; 8'h45: f_sbox = 8'h6e; 8'h46: f_sbox = 8'h5a; 8'h47: f_sbox = 8'ha0;
            8'h48: f_sbox = 8'h52; 8'h49: f_sbox = 8'h3b; 8'h4a: f_sbox = 8'hd6; 8'h4b: f_sbox = 8'hb3; 8'h4c: f_sbox = 8'h29; 8'h4d: f_sbox = 8'he3; 8'h4e: f_sbox = 8'h2f; 8'h4f: f_sbox = 8'h84;
            8'h50: f_sbox = 8'h53; 8'h51: f_sbox = 8'hd1; 8'h52: f_sbox = 8'h00; 8'h53: f_sbox = 8'hed; 8'h54: f_sbox = 8'h20; 8'h55: f_sbox = 8'hfc; 8'h56: f_sbox = 8'hb1; 8'h57: f_sbox = 8'h5b;
            8'h58: f_sbox = 8'h6a; 8'h59: f_sbox = 8'hcb; 8'h5a: f_sbox = 8'hbe; 8'h5b: f_sbox = 8'h39; 8'h5c: f_sbox = 8'h4a; 8'h5d: f_sbox = 8'h4c; 8'h5e: f_sbox = 8'h58; 8'h5f: f_sbox = 8'hcf;
            8'h60: f_sbox = 8'hd0; 8'h61: f_sbox = 8'hef; 8'h62: f_sbox = 8'haa; 8'h63: f_sbox = 8'hfb; 8'h64: f_sbox = 8'h43; 8'h65: f_sbox = 8'h4d; 8'h66: f_sbox = 8'h33; 8'h67: f_sbox = 8'h85;
            8'h68: f_sbox = 8'h45; 8'h69: f_sbox = 8'hf9; 8'h6a: f_sbox = 8'h02; 8'h6b: f_sbox = 8'h7f; 8'h6c: f_sbox = 8'h50; 8'h6d: f_sbox = 8'h3c; 8'h6e: f_sbox = 8'h9f; 8'h6f: f_sbox = 8'ha8;
            8'h70: f_sbox = 8'h51; 8'h71: f_sbox = 8'ha3; 8'h72: f_sbox = 8'h40; 8'h73: f_sbox = 8'h8f; 8'h74: f_sbox = 8'h92; 8'h75: f_sbox = 8'h9d; 8'h76: f_sbox = 8'h38; 8'h77: f_sbox = 8'hf5;
            8'h78: f_sbox = 8'hbc; 8'h79: f_sbox = 8'hb6; 8'h7a: f_sbox = 8'hda; 8'h7b: f_sbox = 8'h21; 8'h7c: f_sbox = 8'h10; 8'h7d: f_sbox = 8'hff; 8'h7e: f_sbox = 8'hf3; 8'h7f: f_sbox = 8'hd2;
            8'h80: f_sbox = 8'hcd; 8'h81: f_sbox = 8'h0c; 8'h82: f_sbox = 8'h13; 8'h83: f_sbox = 8'hec; 8'h84: f_sbox = 8'h5f; 8'h85: f_sbox = 8'h97; 8'h86: f_sbox = 8'h44; 8'h87: f_sbox = 8'h17;
            8'h88: f_sbox = 8'hc4; 8'h89: f_sbox = 8'ha7; 8'h8a: f_sbox = 8'h7e; 8'h8b: f_sbox = 8'h3d; 8'h8c: f_sbox = 8'h64; 8'h8d: f_sbox = 8'h5d; 8'h8e: f_sbox = 8'h19; 8'h8f: f_sbox = 8'h73;
            8'h90: f_sbox = 8'h60; 8'h91: f_sbox = 8'h81; 8'h92: f_sbox = 8'h4f; 8'h93: f_sbox = 8'hdc; 8'h94: f_sbox = 8'h22; 8'h95: f_sbox = 8'h2a; 8'h96: f_sbox = 8'h90; 8'h97: f_sbox = 8'h88;
            8'h98: f_sbox = 8'h46; 8'h99: f_sbox = 8'hee; 8'h9a: f_sbox = 8'hb8; 8'h9b: f_sbox = 8'h14; 8'h9c: f_sbox = 8'hde; 8'h9d: f_sbox = 8'h5e; 8'h9e: f_sbox = 8'h0b; 8'h9f: f_sbox = 8'hdb;
            8'ha0: f_sbox = 8'he0; 8'ha1: f_sbox = 8'h32; 8'ha2: f_sbox = 8'h3a; 8'ha3: f_sbox = 8'h0a; 8'ha4: f_sbox = 8'h49; 8'ha5: f_sbox = 8'h06; 8'ha6: f_sbox = 8'h24; 8'ha7: f_sbox = 8'h5c;
            8'ha8: f_sbox = 8'hc2; 8'ha9: f_sbox = 8'hd3; 8'haa: f_sbox = 8'hac; 8'hab: f_sbox = 8'h62; 8'hac: f_sbox = 8'h91; 8'had: f_sbox = 8'h95; 8'hae: f_sbox = 8'he4; 8'haf: f_sbox = 8'h79;
            8'hb0: f_sbox = 8'he7; 8'hb1: f_sbox = 8'hc8; 8'hb2: f_sbox = 8'h37; 8'hb3: f_sbox = 8'h6d; 8'hb4: f_sbox = 8'h8d; 8'hb5: f_sbox = 8'hd5; 8'hb6: f_sbox = 8'h4e; 8'hb7: f_sbox = 8'ha9;
            8'hb8: f_sbox = 8'h6c; 8'hb9: f_sbox = 8'h56; 8'hba: f_sbox = 8'hf4; 8'hbb: f_sbox = 8'hea; 8'hbc: f_sbox = 8'h65; 8'hbd: f_sbox = 8'h7a; 8'hbe: f_sbox = 8'hae; 8'hbf: f_sbox = 8'h08;
            8'hc0: f_sbox = 8'hba; 8'hc1: f_sbox = 8'h78; 8'hc2: f_sbox = 8'h25; 8'hc3: f_sbox = 8'h2e; 8'hc4: f_sbox = 8'h1c; 8'hc5: f_sbox = 8'ha6; 8'hc6: f_sbox = 8'hb4; 8'hc7: f_sbox = 8'hc6;
            8'hc8: f_sbox = 8'he8; 8'hc9: f_sbox = 8'hdd; 8'hca: f_sbox = 8'h74; 8'hcb: f_sbox = 8'h1f; 8'hcc: f_sbox = 8'h4b; 8'hcd: f_sbox = 8'hbd; 8'hce: f_sbox = 8'h8b; 8'hcf: f_sbox = 8'h8a;
            8'hd0: f_sbox = 8'h70; 8'hd1: f_sbox = 8'h3e; 8'hd2: f_sbox = 8'hb5; 8'hd3: f_sbox = 8'h66; 8'hd4: f_sbox = 8'h48; 8'hd5: f_sbox = 8'h03; 8'hd6: f_sbox = 8'hf6; 8'hd7: f_sbox = 8'h0e;
            8'hd8: f_sbox = 8'h61; 8'hd9: f_sbox = 8'h35; 8'hda: f_sbox = 8'h57; 8'hdb: f_sbox = 8'hb9; 8'hdc: f_sbox = 8'h86; 8'hdd: f_sbox = 8'hc1; 8'hde: f_sbox = 8'h1d; 8'hdf: f_sbox = 8'h9e;
            8'he0: f_sbox = 8'he1; 8'he1: f_sbox = 8'hf8; 8'he2: f_sbox = 8'h98; 8'he3: f_sbox = 8'h11; 8'he4: f_sbox = 8'h69; 8'he5: f_sbox = 8'hd9; 8'he6: f_sbox = 8'h8e; 8'he7: f_sbox = 8'h94;
            8'he8: f_sbox = 8'h9b; 8'he9: f_sbox = 8'h1e; 8'hea: f_sbox = 8'h87; 8'heb: f_sbox = 8'he9; 8'hec: f_sbox = 8'hce; 8'hed: f_sbox = 8'h55; 8'hee: f_sbox = 8'h28; 8'hef: f_sbox = 8'hdf;
            8'hf0: f_sbox = 8'h8c; 8'hf1: f_sbox = 8'ha1; 8'hf2: f_sbox = 8'h89; 8'hf3: f_sbox = 8'h0d; 8'hf4: f_sbox = 8'hbf; 8'hf5: f_sbox = 8'he6; 8'hf6: f_sbox = 8'h42; 8'hf7: f_sbox = 8'h68;
            8'hf8: f_sbox = 8'h41; 8'hf9: f_sbox = 8'h99; 8'hfa: f_sbox = 8'h2d; 8'hfb: f_sbox = 8'h0f; 8'hfc: f_sbox = 8'hb0; 8'hfd: f_sbox = 8'h54; 8'hfe: f_sbox = 8'hbb; 8'hff: f_sbox = 8'h16;
            default: f_sbox = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] f_rcon(input logic [3:0] r);
        f_rcon = 8'h00;
        case (r)
            4'd1:  f_rcon = 8'h01;
            4'd2:  f_rcon = 8'h02;
            4'd3:  f_rcon = 8'h04;
            4'd4:  f_rcon = 8'h08;
            4'd5:  f_rcon = 8'h10;
            4'd6:  f_rcon = 8'h20;
            4'd7:  f_rcon = 8'h40;
            4'd8:  f_rcon = 8'h80;
            4'd9:  f_rcon = 8'h1b;
            4'd10: f_rcon = 8'h36;
            default: f_rcon = 8'h00;
        endcase
    endfunction

    // Undo one forward expansion step; Rcon of the current round is the one that produced it.
    logic [31:0]  w_w0, w_w1, w_w2, w_w3, w_p0, w_p1, w_p2, w_p3, w_rot, w_sub;
    logic [127:0] w_prev_key;

    assign {w_w0, w_w1, w_w2, w_w3} = r_key;
    assign w_p3  = w_w3 ^ w_w2;
    assign w_p2  = w_w2 ^ w_w1;
    assign w_p1  = w_w1 ^ w_w0;
    assign w_rot = {w_p3[23:0], w_p3[31:24]};
    assign w_sub = {f_sbox(w_rot[31:24]), f_sbox(w_rot[23:16]), f_sbox(w_rot[15:8]), f_sbox(w_rot[7:0])};
    assign w_p0  = w_w0 ^ w_sub ^ {f_rcon(r_round), 24'h0};
    assign w_prev_key = {w_p0, w_p1, w_p2, w_p3};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_key         <= '0;
            r_round       <= '0;
            r_valid       <= 1'b0;
            r_start_ready <= 1'b1;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_key         <= last_key;
                        r_round       <= 4'd10;
                        r_state       <= EMIT;
                        r_valid       <= 1'b1;
                        r_start_ready <= 1'b0;
                    end
                end
                EMIT: begin
                    if (rk_ready) begin
                        if (r_round == FINAL_RND) begin
                            r_state       <= IDLE;
                            r_valid       <= 1'b0;
                            r_start_ready <= 1'b1;
                            r_done        <= 1'b1;
                        end else begin
                            r_key   <= w_prev_key;
                            r_round <= r_round - 4'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign start_ready = r_start_ready;
    assign rk_valid    = r_valid;
    assign rk_round    = r_round;
    assign done        = r_done;

`ifdef AES_INV_KEY_EQINV_EN
    function automatic logic [7:0] f_xt(input logic [7:0] a);
        f_xt = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Column InvMixColumns built from x2/x4/x8 multiples: 9=8+1, b=8+2+1, d=8+4+1, e=8+4+2.
    function automatic logic [31:0] f_inv_mix_col(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m9 [4], mb [4], md [4], me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x2    = f_xt(a[i]);
            x4    = f_xt(x2);
            x8    = f_xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        f_inv_mix_col = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                         m9[0] ^ me[1] ^ mb[2] ^ md[3],
                         md[0] ^ m9[1] ^ me[2] ^ mb[3],
                         mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    logic w_mix_en;
    assign w_mix_en = (r_round >= 4'd1) && (r_round <= 4'd9);
    assign rk_data  = w_mix_en ? {f_inv_mix_col(w_w0), f_inv_mix_col(w_w1),
                                  f_inv_mix_col(w_w2), f_inv_mix_col(w_w3)} : r_key;
`else
    assign rk_data = r_key;
`endif

endmodule

// File: tb/tb_aes_inv_key_scheduler.sv
// Scoreboard bench for aes_inv_key_scheduler: FIPS-197 A.1 vector, backpressure, busy start, reset, EMIT_ROUND0=0.
module tb_aes_inv_key_scheduler;
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] last_key;
    logic         start0, rk_ready0, start_ready0, rk_valid0, done0;
    logic [127:0] rk_data0;
    logic [3:0]   rk_round0;
    logic         start1, rk_ready1, start_ready1, rk_valid1, done1;
    logic [127:0] rk_data1;
    logic [3:0]   rk_round1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]   rnd;
        logic [127:0] data;
    } beat_t;
    beat_t sb[$];

    always #5 clk = ~clk;

    aes_inv_key_scheduler #(.EMIT_ROUND0(1)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .start_ready(start_ready0), .last_key(last_key),
        .rk_valid(rk_valid0), .rk_ready(rk_ready0), .rk_data(rk_data0), .rk_round(rk_round0), .done(done0)
    );

    aes_inv_key_scheduler #(.EMIT_ROUND0(0)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .start_ready(start_ready1), .last_key(last_key),
        .rk_valid(rk_valid1), .rk_ready(rk_ready1), .rk_data(rk_data1), .rk_round(rk_round1), .done(done1)
    );

    // FIPS-197 A.1 expansion of 2b7e151628aed2a6abf7158809cf4f3c
    function automatic logic [127:0] ref_key(input int r);
        case (r)
            0:  ref_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
            1:  ref_key = 128'ha0fafe1788542cb123a339392a6c7605;
            2:  ref_key = 128'hf2c295f27a96b9435935807a7359f67f;
            3:  ref_key = 128'h3d80477d4716fe3e1e237e446d7a883b;
            4:  ref_key = 128'hef44a541a8525b7fb671253bdb0bad00;
            5:  ref_key = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
            6:  ref_key = 128'h6d88a37a110b3efddbf98641ca0093fd;
            7:  ref_key = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
            8:  ref_key = 128'head27321b58dbad2312bf5607f8d292f;
            9:  ref_key = 128'hac7766f319fadc2128d12941575c006e;
            default: ref_key = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        endcase
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        gmul = p;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] k);
        logic [7:0] c [4];
        logic [127:0] res;
        res = '0;
        for (int col = 0; col < 4; col++) begin
            for (int i = 0; i < 4; i++) c[i] = k[127-32*col-8*i -: 8];
            res[127-32*col -: 8]    = gmul(c[0], 8'h0e) ^ gmul(c[1], 8'h0b) ^ gmul(c[2], 8'h0d) ^ gmul(c[3], 8'h09);
            res[127-32*col-8 -: 8]  = gmul(c[0], 8'h09) ^ gmul(c[1], 8'h0e) ^ gmul(c[2], 8'h0b) ^ gmul(c[3], 8'h0d);
            res[127-32*col-16 -: 8] = gmul(c[0], 8'h0d) ^ gmul(c[1], 8'h09) ^ gmul(c[2], 8'h0e) ^ gmul(c[3], 8'h0b);
            res[127-32*col-24 -: 8] = gmul(c[0], 8'h0b) ^ gmul(c[1], 8'h0d) ^ gmul(c[2], 8'h09) ^ gmul(c[3], 8'h0e);
        end
        inv_mix = res;
    endfunction

    function automatic logic [127:0] exp_data(input int r);
        exp_data = ref_key(r);
`ifdef AES_INV_KEY_EQINV_EN
        if (r >= 1 && r <= 9) exp_data = inv_mix(ref_key(r));
`endif
    endfunction

    task automatic push_stream(input int lo);
        beat_t b;
        for (int r = 10; r >= lo; r--) begin
            b.rnd = 4'(r);
            b.data = exp_data(r);
            sb.push_back(b);
        end
    endtask

    task automatic pulse_start0();
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (rk_valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rk_valid0); end
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done0); end
        checks++; if (start_ready0 !== 1'b1) begin errors++; $display("FAIL reset_start_ready got %b want 1", start_ready0); end
        checks++; if (rk_round0 !== 4'd0) begin errors++; $display("FAIL reset_round got %0d want 0", rk_round0); end
        checks++; if (rk_data0 !== 128'h0) begin errors++; $display("FAIL reset_data got %h want 0", rk_data0); end
        checks++; if (rk_valid1 !== 1'b0 || start_ready1 !== 1'b1) begin
            errors++; $display("FAIL reset_dut1 got valid=%b sready=%b want 0/1", rk_valid1, start_ready1); end
        @(posedge clk); #1;
    endtask

    task automatic test_vector();
        int beats = 0, vcyc = 0, dones = 0, last_c = -1, done_c = -1;
        beat_t e;
        sb.delete();
        push_stream(0);
        last_key = ref_key(10); rk_ready0 = 1'b1;
        pulse_start0();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done0) begin dones++; done_c = c; end
            if (rk_valid0) begin
                vcyc++;
                checks++; if (start_ready0 !== 1'b0) begin errors++; $display("FAIL vec_sready got %b want 0", start_ready0); end
                if (rk_ready0) begin
                    if (sb.size() == 0) begin errors++; $display("FAIL vec_extra_beat round %0d", rk_round0); end
                    else begin
                        e = sb.pop_front();
                        checks++; if (rk_round0 !== e.rnd || rk_data0 !== e.data) begin
                            errors++; $display("FAIL vec_beat got r%0d %h want r%0d %h", rk_round0, rk_data0, e.rnd, e.data); end
                    end
                    beats++; last_c = c;
                end
            end
            @(posedge clk); #1;
        end
        checks++; if (beats != 11) begin errors++; $display("FAIL vec_beats got %0d want 11", beats); end
        checks++; if (vcyc != 11 || last_c != 10) begin errors++; $display("FAIL vec_consecutive got %0d cycles last %0d want 11 last 10", vcyc, last_c); end
        checks++; if (dones != 1 || done_c != last_c + 1) begin errors++; $display("FAIL vec_done got %0d pulses at %0d want 1 at %0d", dones, done_c, last_c + 1); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL vec_sb_left got %0d want 0", sb.size()); end
    endtask

    task automatic test_backpressure();
        int beats = 0, stalls = 0;
        logic seen_done = 1'b0, stalled = 1'b0;
        logic [127:0] hold_d;
        logic [3:0]   hold_r;
        beat_t e;
        sb.delete();
        push_stream(0);
        last_key = ref_key(10);
        pulse_start0();
        for (int c = 0; c < 300 && !seen_done; c++) begin
            rk_ready0 = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done0) seen_done = 1'b1;
            if (rk_valid0) begin
                if (stalled) begin
                    checks++; if (rk_data0 !== hold_d || rk_round0 !== hold_r) begin
                        errors++; $display("FAIL bp_stable got r%0d %h want r%0d %h", rk_round0, rk_data0, hold_r, hold_d); end
                end
                if (rk_ready0) begin
                    if (sb.size() == 0) begin errors++; $display("FAIL bp_extra_beat round %0d", rk_round0); end
                    else begin
                        e = sb.pop_front();
                        checks++; if (rk_round0 !== e.rnd || rk_data0 !== e.data) begin
                            errors++; $display("FAIL bp_beat got r%0d %h want r%0d %h", rk_round0, rk_data0, e.rnd, e.data); end
                    end
                    beats++; stalled = 1'b0;
                end else begin
                    stalls++; stalled = 1'b1; hold_d = rk_data0; hold_r = rk_round0;
                end
            end
            @(posedge clk); #1;
        end
        checks++; if (!seen_done) begin errors++; $display("FAIL bp_timeout got no done want done"); end
        checks++; if (beats != 11 || sb.size() != 0) begin errors++; $display("FAIL bp_beats got %0d want 11", beats); end
        rk_ready0 = 1'b1;
    endtask

    task automatic test_busy_start();
        logic seen_done = 1'b0, fire = 1'b0, fired = 1'b0;
        beat_t e;
        sb.delete();
        push_stream(0);
        last_key = ref_key(10); rk_ready0 = 1'b1;
        pulse_start0();
        last_key = 128'hffeeddccbbaa99887766554433221100;
        for (int c = 0; c < 30 && !seen_done; c++) begin
            @(negedge clk);
            if (done0) seen_done = 1'b1;
            if (rk_valid0) begin
                checks++; if (start_ready0 !== 1'b0) begin errors++; $display("FAIL busy_sready got %b want 0", start_ready0); end
                if (rk_round0 == 4'd6 && !fired) begin fire = 1'b1; fired = 1'b1; end
                if (sb.size() == 0) begin errors++; $display("FAIL busy_extra_beat round %0d", rk_round0); end
                else begin
                    e = sb.pop_front();
                    checks++; if (rk_round0 !== e.rnd || rk_data0 !== e.data) begin
                        errors++; $display("FAIL busy_beat got r%0d %h want r%0d %h", rk_round0, rk_data0, e.rnd, e.data); end
                end
            end
            @(posedge clk); #1;
            start0 = fire; fire = 1'b0;
        end
        start0 = 1'b0;
        checks++; if (!seen_done || sb.size() != 0) begin errors++; $display("FAIL busy_end got done=%b left=%0d want 1/0", seen_done, sb.size()); end
        @(negedge clk);
        checks++; if (start_ready0 !== 1'b1 || rk_valid0 !== 1'b0) begin
            errors++; $display("FAIL busy_idle got sready=%b valid=%b want 1/0", start_ready0, rk_valid0); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic hit = 1'b0;
        int vbad = 0;
        logic seen_done = 1'b0;
        last_key = ref_key(10); rk_ready0 = 1'b1;
        pulse_start0();
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            if (rk_valid0 && rk_round0 == 4'd4) hit = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checks++; if (!hit) begin errors++; $display("FAIL rstmid_reach got no round 4 want round 4"); end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (rk_valid0 !== 1'b0 || done0 !== 1'b0 || start_ready0 !== 1'b1) begin
            errors++; $display("FAIL rstmid_state got v=%b d=%b sr=%b want 0/0/1", rk_valid0, done0, start_ready0); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rk_valid0 || done0) vbad++;
        end
        checks++; if (vbad != 0) begin errors++; $display("FAIL rstmid_quiet got %0d active cycles want 0", vbad); end
        last_key = 128'h000102030405060708090a0b0c0d0e0f;
        pulse_start0();
        @(negedge clk);
        checks++; if (rk_valid0 !== 1'b1 || rk_round0 !== 4'd10 || rk_data0 !== 128'h000102030405060708090a0b0c0d0e0f) begin
            errors++; $display("FAIL rstmid_restart got v=%b r%0d %h want 1 r10 000102030405060708090a0b0c0d0e0f", rk_valid0, rk_round0, rk_data0); end
        for (int c = 0; c < 20 && !seen_done; c++) begin
            @(negedge clk);
            if (done0) seen_done = 1'b1;
        end
        checks++; if (!seen_done) begin errors++; $display("FAIL rstmid_drain got no done want done"); end
        @(posedge clk); #1;
    endtask

    task automatic test_round0_off();
        int beats = 0, last_c = -1, done_c = -1, dones = 0;
        beat_t e;
        sb.delete();
        push_stream(1);
        last_key = ref_key(10); rk_ready1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done1) begin dones++; done_c = c; end
            if (rk_valid1) begin
                if (sb.size() == 0) begin errors++; $display("FAIL r0off_extra_beat round %0d", rk_round1); end
                else begin
                    e = sb.pop_front();
                    checks++; if (rk_round1 !== e.rnd || rk_data1 !== e.data) begin
                        errors++; $display("FAIL r0off_beat got r%0d %h want r%0d %h", rk_round1, rk_data1, e.rnd, e.data); end
                end
                beats++; last_c = c;
            end
            @(posedge clk); #1;
        end
        checks++; if (beats != 10 || sb.size() != 0) begin errors++; $display("FAIL r0off_beats got %0d want 10", beats); end
        checks++; if (dones != 1 || done_c != last_c + 1) begin errors++; $display("FAIL r0off_done got %0d at %0d want 1 at %0d", dones, done_c, last_c + 1); end
        rk_ready1 = 1'b0;
    endtask

    task automatic test_back_to_back();
        int beats = 0, dones = 0;
        logic fire = 1'b0, fired = 1'b0;
        beat_t e;
        sb.delete();
        push_stream(0);
        push_stream(0);
        last_key = ref_key(10); rk_ready0 = 1'b1;
        pulse_start0();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done0) begin
                dones++;
                if (dones == 1) begin
                    checks++; if (start_ready0 !== 1'b1) begin errors++; $display("FAIL b2b_sready got %b want 1", start_ready0); end
                end
            end
            if (rk_valid0) begin
                if (rk_round0 == 4'd0 && !fired) begin fire = 1'b1; fired = 1'b1; end
                if (sb.size() == 0) begin errors++; $display("FAIL b2b_extra_beat round %0d", rk_round0); end
                else begin
                    e = sb.pop_front();
                    checks++; if (rk_round0 !== e.rnd || rk_data0 !== e.data) begin
                        errors++; $display("FAIL b2b_beat got r%0d %h want r%0d %h", rk_round0, rk_data0, e.rnd, e.data); end
                end
                beats++;
            end
            @(posedge clk); #1;
            start0 = fire; fire = 1'b0;
        end
        start0 = 1'b0;
        checks++; if (beats != 22 || sb.size() != 0) begin errors++; $display("FAIL b2b_beats got %0d want 22", beats); end
        checks++; if (dones != 2) begin errors++; $display("FAIL b2b_dones got %0d want 2", dones); end
    endtask

    initial begin
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; rk_ready0 = 1'b0; rk_ready1 = 1'b0; last_key = '0;
        test_reset();
        test_vector();
        test_backpressure();
        test_busy_start();
        test_reset_mid();
        test_round0_off();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
